// File: rtl/oscilo_pkg.sv
`default_nettype none
// ============================================================================
// Package : oscilo_pkg
// Brief   : Shared capture-controller types and buffer geometry defaults.
// Rev     : 1.0
// ============================================================================
package oscilo_pkg;

    localparam int c_SAMPLE_DEPTH = 8;
    localparam int c_DATA_WIDTH   = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sample_trigger_if.sv
`default_nettype none
// ============================================================================
// Interface : sample_trigger_if
// Brief     : ADC sample strobe in, sample RAM write port out.
// Rev       : 1.0
// ============================================================================
interface sample_trigger_if
    import oscilo_pkg::*;
#(
    parameter int SAMPLE_DEPTH = c_SAMPLE_DEPTH,
    parameter int DATA_WIDTH   = c_DATA_WIDTH
);
    logic                    sample_valid;
    logic [DATA_WIDTH-1:0]   sample_data;
    logic                    wr_en;
    logic [SAMPLE_DEPTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;

    modport master (
        input  sample_valid, sample_data,
        output wr_en, wr_addr, wr_data
    );

    modport slave (
        output sample_valid, sample_data,
        input  wr_en, wr_addr, wr_data
    );
endinterface
`default_nettype wire

// File: rtl/trigger_compare.sv
`default_nettype none
// ============================================================================
// Module : trigger_compare
// Brief  : Level-crossing detector against the previously accepted sample.
// Rev    : 1.0
// ============================================================================
module trigger_compare
    import oscilo_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH
) (
    input  wire logic                  clk_50mhz,
    input  wire logic                  reset,
    input  wire logic                  i_clear,
    input  wire logic                  i_accept,
    input  wire logic [DATA_WIDTH-1:0] i_sample_data,
    input  wire logic [DATA_WIDTH-1:0] i_level,
    input  wire logic                  i_rising,
    output logic                       o_fire
);
    logic [DATA_WIDTH-1:0] r_prev;
    logic                  r_prev_valid;
    logic                  w_prev_below;
    logic                  w_cur_below;

    always_ff @(posedge clk_50mhz) begin
        if (!reset) begin
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
        end else if (i_clear) begin
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
        end else if (i_accept) begin
            r_prev       <= i_sample_data;
            r_prev_valid <= 1'b1;
        end
    end

    assign w_prev_below = (r_prev < i_level);
    assign w_cur_below  = (i_sample_data < i_level);
    assign o_fire = r_prev_valid &&
                    (i_rising ? (w_prev_below && !w_cur_below)
                              : (!w_prev_below && w_cur_below));
endmodule
`default_nettype wire

// File: rtl/sample_trigger.sv
`default_nettype none
// ============================================================================
// Module : sample_trigger
// Brief  : Pre/post-trigger capture controller writing ADC samples to RAM.
// Rev    : 1.0
// ============================================================================
module sample_trigger
    import oscilo_pkg::*;
#(
    parameter int SAMPLE_DEPTH = c_SAMPLE_DEPTH,
    parameter int DATA_WIDTH   = c_DATA_WIDTH
) (
    input  wire logic                    clk_50mhz,
    input  wire logic                    reset,
    input  wire logic                    activate,
    output logic                         done,
    sample_trigger_if.master             bus,
    input  wire logic [DATA_WIDTH-1:0]   trigger_level,
    input  wire logic                    trigger_rising,
    input  wire logic                    force_trigger,
    input  wire logic [SAMPLE_DEPTH-1:0] post_count,
    output logic [SAMPLE_DEPTH-1:0]      offset,
    output logic                         triggered
);
    localparam logic [SAMPLE_DEPTH-1:0] c_PTR_MAX = '1;

    state_t                  r_state;
    logic [SAMPLE_DEPTH-1:0] r_ptr;
    logic [SAMPLE_DEPTH-1:0] r_pre_cnt;
    logic [SAMPLE_DEPTH-1:0] r_post_cnt;
    logic [SAMPLE_DEPTH-1:0] r_target;
    logic [SAMPLE_DEPTH-1:0] r_cfg_post;
    logic [DATA_WIDTH-1:0]   r_cfg_level;
    logic                    r_cfg_rising;
    logic                    r_done;
    logic                    r_wr_en;
    logic [SAMPLE_DEPTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0]   r_wr_data;
    logic [SAMPLE_DEPTH-1:0] r_offset;
    logic                    r_triggered;

    logic                    w_capturing;
    logic                    w_post_full;
    logic                    w_write;
    logic                    w_clear;
    logic                    w_fire;
    logic [SAMPLE_DEPTH-1:0] w_pre_next;

    assign w_capturing = (r_state == ST_PRE) || (r_state == ST_ARMED) || (r_state == ST_POST);
    assign w_post_full = (r_state == ST_POST) && (r_post_cnt == r_cfg_post);
    assign w_write     = w_capturing && activate && !w_post_full && bus.sample_valid;
    assign w_clear     = (r_state == ST_IDLE) && activate;
    assign w_pre_next  = r_pre_cnt + 1'b1;

    trigger_compare #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_compare (
        .clk_50mhz     (clk_50mhz),
        .reset         (reset),
        .i_clear       (w_clear),
        .i_accept      (w_write),
        .i_sample_data (bus.sample_data),
        .i_level       (r_cfg_level),
        .i_rising      (r_cfg_rising),
        .o_fire        (w_fire)
    );

    always_ff @(posedge clk_50mhz) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_pre_cnt    <= '0;
            r_post_cnt   <= '0;
            r_target     <= '0;
            r_cfg_post   <= '0;
            r_cfg_level  <= '0;
            r_cfg_rising <= 1'b0;
            r_done       <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_offset     <= '0;
            r_triggered  <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (activate) begin
                        r_ptr        <= '0;
                        r_pre_cnt    <= '0;
                        r_post_cnt   <= '0;
                        r_triggered  <= 1'b0;
                        r_cfg_level  <= trigger_level;
                        r_cfg_rising <= trigger_rising;
                        r_cfg_post   <= post_count;
                        r_target     <= c_PTR_MAX - post_count;
                        r_state      <= ST_PRE;
                    end
                end
                ST_PRE, ST_ARMED, ST_POST: begin
                    if (!activate) begin
                        r_done  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_post_full) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (bus.sample_valid) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_ptr;
                        r_wr_data <= bus.sample_data;
                        r_ptr     <= r_ptr + 1'b1;
                        if (r_state == ST_PRE) begin
                            // Target 0 means post_count fills the buffer: arm on the first sample.
                            r_pre_cnt <= w_pre_next;
                            if ((w_pre_next == r_target) || (r_target == '0)) begin
                                r_state <= ST_ARMED;
                            end
                        end else if (r_state == ST_ARMED) begin
                            if (w_fire || force_trigger) begin
                                r_offset    <= r_ptr;
                                r_triggered <= 1'b1;
                                r_state     <= ST_POST;
                            end
                        end else begin
                            r_post_cnt <= r_post_cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (!activate) begin
                        r_done  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign done        = r_done;
    assign offset      = r_offset;
    assign triggered   = r_triggered;
    assign bus.wr_en   = r_wr_en;
    assign bus.wr_addr = r_wr_addr;
    assign bus.wr_data = r_wr_data;
endmodule
`default_nettype wire

// File: tb/tb_sample_trigger.sv
`default_nettype none
// ============================================================================
// Module : tb_sample_trigger
// Brief  : Directed + randomized capture scenarios against a sample-index model.
// Rev    : 1.0
// ============================================================================
module tb_sample_trigger;
    logic       clk_50mhz = 1'b0;
    logic       reset = 1'b0;
    logic       activate = 1'b0;
    logic       done;
    logic [7:0] trigger_level = 8'h80;
    logic       trigger_rising = 1'b1;
    logic       force_trigger = 1'b0;
    logic [7:0] post_count = 8'd16;
    logic [7:0] offset;
    logic       triggered;

    sample_trigger_if #(.SAMPLE_DEPTH(8), .DATA_WIDTH(8)) bus ();

    sample_trigger #(.SAMPLE_DEPTH(8), .DATA_WIDTH(8)) dut (
        .clk_50mhz      (clk_50mhz),
        .reset          (reset),
        .activate       (activate),
        .done           (done),
        .bus            (bus),
        .trigger_level  (trigger_level),
        .trigger_rising (trigger_rising),
        .force_trigger  (force_trigger),
        .post_count     (post_count),
        .offset         (offset),
        .triggered      (triggered)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Model: a capture is a numbered sequence of written samples; index < pre_len is pre-trigger.
    bit         m_idle = 1'b1, m_cap = 1'b0, m_fin = 1'b0;
    int         m_n, m_trig, m_post_seen, m_pre_len;
    logic [7:0] m_prev, m_cfg_level, m_cfg_post;
    bit         m_cfg_rising;
    logic       e_done = 0, e_wr_en = 0, e_triggered = 0;
    logic [7:0] e_wr_addr = 0, e_wr_data = 0, e_offset = 0;

    function automatic bit crosses(input logic [7:0] p, input logic [7:0] c);
        if (m_cfg_rising) return (p < m_cfg_level) && (c >= m_cfg_level);
        else              return (p >= m_cfg_level) && (c < m_cfg_level);
    endfunction

    task automatic model_step();
        if (!reset) begin
            {e_done, e_wr_en, e_triggered} = '0;
            {e_wr_addr, e_wr_data, e_offset} = '0;
            m_idle = 1'b1; m_cap = 1'b0; m_fin = 1'b0;
            return;
        end
        e_wr_en = 1'b0;
        if (m_idle) begin
            if (activate) begin
                m_idle = 1'b0; m_cap = 1'b1;
                m_n = 0; m_trig = -1; m_post_seen = 0;
                m_cfg_level = trigger_level; m_cfg_rising = trigger_rising; m_cfg_post = post_count;
                m_pre_len = (post_count == 8'd255) ? 1 : 255 - int'(post_count);
                e_triggered = 1'b0;
            end
        end else if (m_cap) begin
            if (!activate) begin
                m_cap = 1'b0; m_idle = 1'b1;
            end else if (m_trig >= 0 && m_post_seen == int'(m_cfg_post)) begin
                m_cap = 1'b0; m_fin = 1'b1; e_done = 1'b1;
            end else if (bus.sample_valid) begin
                e_wr_en = 1'b1;
                e_wr_addr = m_n[7:0];
                e_wr_data = bus.sample_data;
                if (m_n >= m_pre_len) begin
                    if (m_trig < 0) begin
                        if (force_trigger || (m_n >= 1 && crosses(m_prev, bus.sample_data))) begin
                            m_trig = m_n; e_offset = e_wr_addr; e_triggered = 1'b1;
                        end
                    end else begin
                        m_post_seen++;
                    end
                end
                m_prev = bus.sample_data;
                m_n++;
            end
        end else if (m_fin) begin
            if (!activate) begin
                m_fin = 1'b0; m_idle = 1'b1; e_done = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_50mhz);
        model_step();
        #1;
        check("done", done, e_done);
        check("wr_en", bus.wr_en, e_wr_en);
        check("triggered", triggered, e_triggered);
        check("offset", offset, e_offset);
        if (e_wr_en) begin
            check("wr_addr", bus.wr_addr, e_wr_addr);
            check("wr_data", bus.wr_data, e_wr_data);
        end
    endtask

    task automatic sample(input logic [7:0] d, input int gap, input bit frc);
        bus.sample_valid = 1'b1; bus.sample_data = d; force_trigger = frc;
        tick();
        bus.sample_valid = 1'b0; force_trigger = 1'b0;
        repeat (gap - 1) tick();
    endtask

    task automatic arm(input logic [7:0] lvl, input bit rising, input logic [7:0] post);
        trigger_level = lvl; trigger_rising = rising; post_count = post; activate = 1'b1;
        tick();
    endtask

    task automatic disarm();
        activate = 1'b0;
        tick(); tick();
    endtask

    initial begin
        bus.sample_valid = 1'b0;
        bus.sample_data  = '0;
        repeat (3) tick();
        check("rst_done", done, 0);
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_wr_addr", bus.wr_addr, 0);
        check("rst_offset", offset, 0);
        reset = 1'b1;
        tick();

        // Ramp: trigger sample 0x80 lands at address 0xF0.
        arm(8'h80, 1'b1, 8'd16);
        for (int i = 0; i < 600 && !m_fin; i++) sample(8'(8'h90 + i), 4, 1'b0);
        check("A_offset", offset, 8'hF0);
        check("A_done", done, 1);
        check("A_triggered", triggered, 1);
        disarm();
        check("A_done_clear", done, 0);

        // Ramp from 0: the PRE crossing is ignored, the next one at address 0x80 is taken.
        arm(8'h80, 1'b1, 8'd16);
        for (int i = 0; i < 800 && !m_fin; i++) sample(8'(i), 2, 1'b0);
        check("B_offset", offset, 8'h80);
        check("B_done", done, 1);
        disarm();

        // Falling edge, level 0x40.
        arm(8'h40, 1'b0, 8'd16);
        for (int i = 0; i < 250; i++) sample(8'h50, 2, 1'b0);
        for (int i = 0; i < 100 && !m_fin; i++) sample(8'h30, 2, 1'b0);
        check("C_offset", offset, 8'hFA);
        check("C_done", done, 1);
        disarm();
        arm(8'h40, 1'b0, 8'd16);
        for (int i = 0; i < 400; i++) sample(8'h40, 2, 1'b0);
        check("C_never", triggered, 0);
        check("C_never_done", done, 0);
        disarm();

        // post_count=0 with forced trigger; force without a sample is a no-op.
        arm(8'h80, 1'b1, 8'd0);
        for (int i = 0; i < 255; i++) sample(8'h00, 1, 1'b0);
        force_trigger = 1'b1;
        repeat (3) tick();
        check("D_force_only", triggered, 0);
        sample(8'h00, 1, 1'b1);
        check("D_offset", offset, 8'hFF);
        tick();
        check("D_done", done, 1);
        check("D_wr_en", bus.wr_en, 0);
        sample(8'h11, 2, 1'b0);
        check("D_wr_en_after", bus.wr_en, 0);
        disarm();

        // Abort mid-POST, then re-arm restarts at address 0.
        arm(8'h80, 1'b1, 8'd16);
        for (int i = 0; i < 239; i++) sample(8'h10, 1, 1'b0);
        sample(8'h10, 1, 1'b1);
        for (int i = 0; i < 5; i++) sample(8'h20, 2, 1'b0);
        activate = 1'b0;
        tick();
        check("E_abort_done", done, 0);
        for (int i = 0; i < 4; i++) sample(8'h33, 1, 1'b0);
        check("E_abort_wr_en", bus.wr_en, 0);
        check("E_offset_kept", offset, 8'd239);
        arm(8'h80, 1'b1, 8'd16);
        bus.sample_valid = 1'b1; bus.sample_data = 8'h55;
        tick();
        bus.sample_valid = 1'b0;
        check("E_rearm_wr_en", bus.wr_en, 1);
        check("E_rearm_addr", bus.wr_addr, 0);
        disarm();

        // Reset while ARMED.
        arm(8'h80, 1'b1, 8'd16);
        for (int i = 0; i < 241; i++) sample(8'h10, 1, 1'b0);
        bus.sample_valid = 1'b1; bus.sample_data = 8'hC0;
        reset = 1'b0;
        tick();
        bus.sample_valid = 1'b0;
        check("F_wr_en", bus.wr_en, 0);
        check("F_wr_addr", bus.wr_addr, 0);
        check("F_wr_data", bus.wr_data, 0);
        check("F_done", done, 0);
        check("F_offset", offset, 0);
        check("F_triggered", triggered, 0);
        reset = 1'b1; activate = 1'b0;
        tick();

        // Randomized captures; config inputs are scrambled after arming.
        for (int r = 0; r < 8; r++) begin
            arm(8'($urandom), 1'($urandom), (r % 2) ? 8'($urandom) : 8'($urandom_range(0, 20)));
            trigger_level = 8'($urandom); trigger_rising = 1'($urandom); post_count = 8'($urandom);
            for (int c = 0; c < 2000 && m_cap; c++) begin
                bus.sample_valid = ($urandom % 3 == 0);
                bus.sample_data  = 8'($urandom);
                force_trigger    = ($urandom % 300 == 0);
                if ($urandom % 2500 == 0) activate = 1'b0;
                reset = ($urandom % 4000 != 0);
                tick();
            end
            bus.sample_valid = 1'b0; force_trigger = 1'b0; reset = 1'b1;
            repeat (3) tick();
            disarm();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sample_trigger.md
SAMPLE_TRIGGER -- requirements
Module: sample_trigger

Interface
REQ-001 The module SHALL have parameter SAMPLE_DEPTH, default 8, which is the buffer address width; the buffer holds 2^SAMPLE_DEPTH samples.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 8, which is the ADC sample width.
REQ-003 clk_50mhz  in  1  sole clock; all logic is clocked on its rising edge.
REQ-004 reset  in  1  reset, synchronous and active-low.
REQ-005 activate  in  1  arm request; held high for the whole capture.
REQ-006 done  out  1  capture complete; valid while activate is high.
REQ-007 sample_valid  in  1  single-cycle ADC sample strobe.
REQ-008 sample_data  in  DATA_WIDTH  ADC sample.
REQ-009 trigger_level  in  DATA_WIDTH  trigger threshold, unsigned.
REQ-010 trigger_rising  in  1  edge select: 1 = rising, 0 = falling.
REQ-011 force_trigger  in  1  manual trigger.
REQ-012 post_count  in  SAMPLE_DEPTH  number of samples to capture after the trigger sample.
REQ-013 wr_en, wr_addr, wr_data  out  1 / SAMPLE_DEPTH / DATA_WIDTH  sample RAM write port.
REQ-014 offset  out  SAMPLE_DEPTH  RAM address of the trigger sample; consumed by the offset transmitter.
REQ-015 triggered  out  1  status: a trigger has been accepted in the current capture.

Function
REQ-016 The state machine SHALL have states IDLE, PRE, ARMED, POST and DONE.
REQ-017 IDLE: when activate=1, the block SHALL clear the write pointer, the pre/post counters, prev_valid and triggered, then go to PRE.
REQ-018 In PRE, ARMED and POST, each sample_valid SHALL write sample_data to the write pointer and then increment the pointer modulo 2^SAMPLE_DEPTH.
REQ-019 wr_en, wr_addr and wr_data SHALL be registered, with wr_en high exactly one cycle after the sample_valid edge; wr_en SHALL be 0 in IDLE and DONE.
REQ-020 PRE: the block SHALL count written samples and go to ARMED on the write that makes the count equal to (2^SAMPLE_DEPTH - 1 - post_count), computed modulo 2^SAMPLE_DEPTH; if the target is 0, it SHALL go to ARMED on the first sample.
REQ-021 Trigger compare, with prev = the previous accepted sample: rising fires when prev < trigger_level and sample_data >= trigger_level; falling fires when prev >= trigger_level and sample_data < trigger_level.
REQ-022 The compare SHALL be inhibited until prev_valid=1, i.e. until one sample has been accepted since arming.
REQ-023 Samples written in PRE SHALL update prev, but trigger events in PRE SHALL be ignored.
REQ-024 ARMED: a trigger event, or force_trigger=1, coincident with sample_valid SHALL make that sample the trigger sample.
REQ-025 On a trigger, the block SHALL latch offset = its write address, set triggered=1 and go to POST; force_trigger without sample_valid SHALL have no effect.
REQ-026 POST: the block SHALL count further samples and go to DONE in the cycle after the write of the post_count-th sample; if post_count=0, it SHALL go to DONE the cycle after the trigger sample write.
REQ-027 DONE: done SHALL be 1, and offset and triggered SHALL be held; when activate=0 the block SHALL clear done and go to IDLE.
REQ-028 If activate falls in PRE, ARMED or POST, the block SHALL abort to IDLE next cycle with done=0 and SHALL NOT issue further writes; offset SHALL keep its previous value.
REQ-029 trigger_level, trigger_rising and post_count SHALL be sampled once on arming and held constant for the capture.
REQ-030 A sample_valid arriving in the same cycle as the PRE-to-ARMED transition SHALL count as a PRE sample.

Reset
REQ-031 While reset=0 at a clock edge, the state SHALL be IDLE and done, wr_en, wr_addr, wr_data, offset, triggered, prev_valid and all counters SHALL be 0.
REQ-032 A reset in any state SHALL abort the capture without issuing a partial write on the following cycle.

Structure
REQ-033 The state enum and the SAMPLE_DEPTH/DATA_WIDTH defaults SHALL live in the shared package oscilo_pkg.
REQ-034 The edge compare (prev register, prev_valid, rising/falling logic) SHALL be the sub-module trigger_compare.

Verification
REQ-035 Verification SHALL use SAMPLE_DEPTH=8, post_count=16, rising, level=0x80.
- Ramp 0x00..0xFF, one sample every 4 cycles -> trigger at the sample 0x80 (written after 239 PRE samples) -> offset=0xF0; done one cycle after the 16th post write.
- Crossing located inside PRE (ramp restart) -> no trigger; the first crossing in ARMED is taken; writes wrap 0xFF -> 0x00 with no gap.
- Falling edge, level=0x40, constant 0x50 then 0x30 -> trigger on 0x30; 0x40 held forever -> never triggers.
- post_count=0 with force_trigger plus sample_valid in ARMED -> DONE next cycle; wr_en low afterwards.
- activate dropped mid-POST -> IDLE with done=0 and no further wr_en; re-arm starts writing at wr_addr=0.
- reset=0 asserted in ARMED -> every output 0 on the next cycle.
